// File: rtl/aes_pkg.sv
// Shared Rijndael ShiftRows helpers: legal state widths, row offsets and
// column/byte index arithmetic used by the column-serial datapath.
package aes_pkg;

    localparam int COL_W  = 32;
    localparam int BYTE_W = 8;
    localparam int ROWS   = 4;

    function automatic bit nb_legal(input int nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

    // Row offset C_r; 256-bit states skip offset 2 on the lower rows.
    function automatic int shift_offset(input int nb, input int r);
        if (nb == 8 && r >= 2) begin
            return r + 1;
        end
        return r;
    endfunction

    function automatic int src_col(input int nb, input int c, input int r, input bit inv);
        if (inv) begin
            return (c - shift_offset(nb, r) + nb) % nb;
        end
        return (c + shift_offset(nb, r)) % nb;
    endfunction

    function automatic int byte_idx(input int c, input int r);
        return ROWS * c + r;
    endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation over a full state.
// Every output byte is a two-way mux between its forward and inverse source.
module shift_rows_perm
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic [32*NB-1:0] state_in,
    input  logic             inv,
    output logic [32*NB-1:0] state_out
);

    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < ROWS; r++) begin : g_row
            localparam int DST = byte_idx(c, r);
            localparam int FWD = byte_idx(src_col(NB, c, r, 1'b0), r);
            localparam int INV = byte_idx(src_col(NB, c, r, 1'b1), r);

            assign state_out[BYTE_W*DST +: BYTE_W] = inv ? state_in[BYTE_W*INV +: BYTE_W]
                                                         : state_in[BYTE_W*FWD +: BYTE_W];
        end
    end

endmodule

// File: rtl/shift_rows_stream.sv
// Column-serial ShiftRows stage: collects NB column beats, permutes on the
// final beat and holds the shifted state in a registered output buffer.
module shift_rows_stream
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_inv,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [32*NB-1:0] out_data,
    output logic             out_inv
);

    localparam int CW = $clog2(NB);
    localparam logic [CW-1:0] LAST_COL = CW'(NB - 1);

    if (!nb_legal(NB)) begin : g_nb_check
        $error("shift_rows_stream: NB must be 4, 6 or 8");
    end

    logic [CW-1:0]           col_cnt;
    logic [32*(NB-1)-1:0]    collect;
    logic                    mode;
    logic                    last_beat;
    logic                    accept;
    logic                    final_accept;
    logic [32*NB-1:0]        state_full;
    logic [32*NB-1:0]        state_next;

    assign last_beat = (col_cnt == LAST_COL);

    // Only the final beat waits for the output buffer to free up.
    assign in_ready     = ~last_beat | ~out_valid | out_ready;
    assign accept       = in_valid & in_ready & ~flush;
    assign final_accept = accept & last_beat;

    // Final column comes straight from the bus so the state lands in one cycle.
    assign state_full = {in_data, collect};

    shift_rows_perm #(
        .NB(NB)
    ) u_perm (
        .state_in (state_full),
        .inv      (mode),
        .state_out(state_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt <= '0;
            collect <= '0;
            mode    <= 1'b0;
        end else if (flush) begin
            col_cnt <= '0;
        end else if (accept) begin
            if (last_beat) begin
                col_cnt <= '0;
            end else begin
                col_cnt <= col_cnt + 1'b1;
                for (int k = 0; k < NB - 1; k++) begin
                    if (col_cnt == CW'(k)) begin
                        collect[32*k +: 32] <= in_data;
                    end
                end
                if (col_cnt == '0) begin
                    mode <= in_inv;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_inv   <= 1'b0;
        end else if (final_accept) begin
            out_valid <= 1'b1;
            out_data  <= state_next;
            out_inv   <= mode;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_rows_stream.sv
// Directed bench for shift_rows_stream at NB=4 and NB=8: table vectors plus
// backpressure, flush and asynchronous reset sequences.
module tb_shift_rows_stream;

    logic clk = 1'b0;
    logic rst;

    logic         flush4, in_valid4, in_ready4, in_inv4, out_valid4, out_ready4, out_inv4;
    logic [31:0]  in_data4;
    logic [127:0] out_data4;

    logic         flush8, in_valid8, in_ready8, in_inv8, out_valid8, out_ready8, out_inv8;
    logic [31:0]  in_data8;
    logic [255:0] out_data8;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    shift_rows_stream #(.NB(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush4),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_inv(in_inv4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4), .out_inv(out_inv4)
    );

    shift_rows_stream #(.NB(8)) dut8 (
        .clk(clk), .rst(rst), .flush(flush8),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_inv(in_inv8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8), .out_inv(out_inv8)
    );

    typedef struct {
        string        name;
        logic [127:0] data;
        logic         inv;
        logic [127:0] exp;
    } vec4_t;

    vec4_t vecs [4];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Beat 0 carries the real mode; later beats carry the opposite to prove it is ignored.
    task automatic send4(input logic [127:0] d, input logic inv);
        for (int k = 0; k < 4; k++) begin
            in_valid4 = 1'b1;
            in_data4  = d[32*k +: 32];
            in_inv4   = (k == 0) ? inv : ~inv;
            tick();
        end
        in_valid4 = 1'b0;
    endtask

    task automatic send8(input logic [255:0] d, input logic inv);
        for (int k = 0; k < 8; k++) begin
            in_valid8 = 1'b1;
            in_data8  = d[32*k +: 32];
            in_inv8   = (k == 0) ? inv : ~inv;
            tick();
        end
        in_valid8 = 1'b0;
    endtask

    localparam logic [127:0] ID4    = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] FWD4   = 128'h0B06010C_07020D08_030E0904_0F0A0500;
    localparam logic [255:0] ID8    = 256'h1F1E1D1C_1B1A1918_17161514_13121110_0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [255:0] FWD8   = 256'h0F0A011C_0B061D18_07021914_031E1510_1F1A110C_1B160D08_17120904_130E0500;
    localparam logic [127:0] BLK_A  = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;

    initial begin
        logic [255:0] fwd8_got;

        vecs[0] = '{"fwd_id",   ID4,  1'b0, FWD4};
        vecs[1] = '{"inv_fwd",  FWD4, 1'b1, ID4};
        vecs[2] = '{"fwd_id10", 128'h1F1E1D1C_1B1A1918_17161514_13121110, 1'b0,
                    128'h1B16111C_17121D18_131E1914_1F1A1510};
        vecs[3] = '{"inv_id",   ID4,  1'b1, 128'h0306090C_0F020508_0B0E0104_070A0D00};

        rst = 1'b1;
        flush4 = 0; in_valid4 = 0; in_inv4 = 0; in_data4 = '0; out_ready4 = 1;
        flush8 = 0; in_valid8 = 0; in_inv8 = 0; in_data8 = '0; out_ready8 = 1;
        tick();
        tick();
        check("rst_out_valid", {255'd0, out_valid4}, 256'd0);
        check("rst_out_data",  {128'd0, out_data4}, 256'd0);
        check("rst_out_inv",   {255'd0, out_inv4}, 256'd0);
        check("rst_in_ready",  {255'd0, in_ready4}, 256'd1);
        rst = 1'b0;
        tick();

        // Table vectors streamed back to back; each check lands one edge after the final beat.
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                in_valid4 = 1'b1;
                in_data4  = vecs[i].data[32*k +: 32];
                in_inv4   = (k == 0) ? vecs[i].inv : ~vecs[i].inv;
                tick();
            end
            check({vecs[i].name, "_valid"}, {255'd0, out_valid4}, 256'd1);
            check({vecs[i].name, "_data"},  {128'd0, out_data4}, {128'd0, vecs[i].exp});
            check({vecs[i].name, "_inv"},   {255'd0, out_inv4}, {255'd0, vecs[i].inv});
        end
        in_valid4 = 1'b0;
        tick();
        check("drain_clears_valid", {255'd0, out_valid4}, 256'd0);

        // NB=8 forward, then round trip through the inverse.
        send8(ID8, 1'b0);
        fwd8_got = out_data8;
        check("nb8_valid",  {255'd0, out_valid8}, 256'd1);
        check("nb8_lo32",   {224'd0, out_data8[31:0]}, {224'd0, 32'h130E0500});
        check("nb8_hi32",   {224'd0, out_data8[63:32]}, {224'd0, 32'h17120904});
        check("nb8_full",   out_data8, FWD8);
        send8(FWD8, 1'b1);
        check("nb8_inv",    {255'd0, out_inv8}, 256'd1);
        check("nb8_round",  out_data8, ID8);
        send8(fwd8_got, 1'b1);
        check("nb8_round2", out_data8, ID8);

        // Backpressure: A held, B's first beats still accepted, final beat stalls.
        out_ready4 = 1'b0;
        send4(ID4, 1'b0);
        check("bp_a_valid", {255'd0, out_valid4}, 256'd1);
        for (int k = 0; k < 3; k++) begin
            in_valid4 = 1'b1;
            in_data4  = FWD4[32*k +: 32];
            in_inv4   = (k == 0);
            #1;
            check("bp_early_ready", {255'd0, in_ready4}, 256'd1);
            tick();
        end
        in_data4 = FWD4[127:96];
        in_inv4  = 1'b0;
        for (int n = 0; n < 3; n++) begin
            check("bp_final_stall", {255'd0, in_ready4}, 256'd0);
            check("bp_a_stable",    {128'd0, out_data4}, {128'd0, FWD4});
            check("bp_a_inv",       {255'd0, out_inv4}, 256'd0);
            tick();
        end
        out_ready4 = 1'b1;
        #1;
        check("bp_release_ready", {255'd0, in_ready4}, 256'd1);
        check("bp_valid_before",  {255'd0, out_valid4}, 256'd1);
        tick();
        in_valid4 = 1'b0;
        check("bp_valid_nogap", {255'd0, out_valid4}, 256'd1);
        check("bp_b_data",      {128'd0, out_data4}, {128'd0, ID4});
        check("bp_b_inv",       {255'd0, out_inv4}, 256'd1);
        tick();
        check("bp_drained", {255'd0, out_valid4}, 256'd0);

        // Flush: two beats of A, a flushed beat, then a clean block B.
        for (int k = 0; k < 2; k++) begin
            in_valid4 = 1'b1;
            in_data4  = BLK_A[32*k +: 32];
            in_inv4   = 1'b1;
            tick();
        end
        flush4   = 1'b1;
        in_data4 = BLK_A[95:64];
        #1;
        check("flush_ready", {255'd0, in_ready4}, 256'd1);
        tick();
        flush4 = 1'b0;
        in_valid4 = 1'b0;
        check("flush_no_out", {255'd0, out_valid4}, 256'd0);
        send4(ID4, 1'b0);
        check("flush_b_valid", {255'd0, out_valid4}, 256'd1);
        check("flush_b_data",  {128'd0, out_data4}, {128'd0, FWD4});
        check("flush_b_inv",   {255'd0, out_inv4}, 256'd0);

        // Flush leaves a held output untouched.
        out_ready4 = 1'b0;
        tick();
        flush4 = 1'b1;
        tick();
        flush4 = 1'b0;
        check("flush_keeps_valid", {255'd0, out_valid4}, 256'd1);
        check("flush_keeps_data",  {128'd0, out_data4}, {128'd0, FWD4});

        // Async reset mid-collection with a pending output.
        send4(FWD4, 1'b1);
        for (int k = 0; k < 2; k++) begin
            in_valid4 = 1'b1;
            in_data4  = BLK_A[32*k +: 32];
            in_inv4   = 1'b1;
            tick();
        end
        in_valid4 = 1'b0;
        check("pre_rst_valid", {255'd0, out_valid4}, 256'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", {255'd0, out_valid4}, 256'd0);
        check("arst_out_data",  {128'd0, out_data4}, 256'd0);
        check("arst_out_inv",   {255'd0, out_inv4}, 256'd0);
        check("arst_col_cnt",   {254'd0, dut4.col_cnt}, 256'd0);
        #1;
        rst = 1'b0;
        out_ready4 = 1'b1;
        tick();
        send4(FWD4, 1'b1);
        check("post_rst_data", {128'd0, out_data4}, {128'd0, ID4});
        check("post_rst_inv",  {255'd0, out_inv4}, 256'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
